// File: rtl/dm_access_ctrl.sv
// Data-memory access controller: sequences one load/store at a time against a word-wide memory,
// with read-merge-write for sub-word stores, load extension, and error responses for bad addresses.
module dm_access_ctrl #(
  parameter int unsigned SIZE = 4096
) (
  input  logic        clk,
  input  logic        Reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_op,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [31:0] req_pc,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [31:0] resp_rdata,
  output logic [31:0] mem_A,
  output logic [31:0] mem_WD,
  output logic        mem_WE,
  output logic        mem_RE,
  input  logic [31:0] mem_RD,
  output logic [31:0] mem_PC,
  output logic        busy
);

  typedef enum logic [2:0] {
    OP_LW  = 3'd0,
    OP_LBU = 3'd1,
    OP_LB  = 3'd2,
    OP_LHU = 3'd3,
    OP_LH  = 3'd4,
    OP_SW  = 3'd5,
    OP_SB  = 3'd6,
    OP_SH  = 3'd7
  } op_e;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_MERGE,
    S_WRITE,
    S_RESP
  } state_e;

  localparam logic [31:0] ADDR_LIMIT = 32'(SIZE * 4);

  state_e      state, state_next;
  op_e         op_q;
  logic [31:0] addr_q;
  logic [31:0] pc_q;
  logic [31:0] wbuf;
  logic [31:0] rdata_q;
  logic        err_q;

  logic        accept;
  logic        req_bad;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  logic [31:0] merge_val;

  assign accept = req_valid && req_ready;

  // Out-of-range or misaligned for the access width.
  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    req_bad = (req_addr >= ADDR_LIMIT);
    case (op_e'(req_op))
      OP_LW, OP_SW:         if (req_addr[1:0] != 2'b00) req_bad = 1'b1;
      OP_LH, OP_LHU, OP_SH: if (req_addr[0])            req_bad = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = mem_RD[7:0];
    case (addr_q[1:0])
      2'd1:    ld_byte = mem_RD[15:8];
      2'd2:    ld_byte = mem_RD[23:16];
      2'd3:    ld_byte = mem_RD[31:24];
      default: ld_byte = mem_RD[7:0];
    endcase
    ld_half = addr_q[1] ? mem_RD[31:16] : mem_RD[15:0];

    case (op_q)
      OP_LBU:  ld_val = {24'h0, ld_byte};
      OP_LB:   ld_val = {{24{ld_byte[7]}}, ld_byte};
      OP_LHU:  ld_val = {16'h0, ld_half};
      OP_LH:   ld_val = {{16{ld_half[15]}}, ld_half};
      default: ld_val = mem_RD;
    endcase

    // wbuf still holds the raw store data while in MERGE.
    merge_val = mem_RD;
    if (op_q == OP_SH) begin
      if (addr_q[1]) merge_val[31:16] = wbuf[15:0];
      else           merge_val[15:0]  = wbuf[15:0];
    end else begin
      case (addr_q[1:0])
        2'd1:    merge_val[15:8]  = wbuf[7:0];
        2'd2:    merge_val[23:16] = wbuf[7:0];
        2'd3:    merge_val[31:24] = wbuf[7:0];
        default: merge_val[7:0]   = wbuf[7:0];
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) state <= S_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_err   = 1'b0;
    resp_rdata = 32'h0;
    mem_WE     = 1'b0;
    mem_WD     = 32'h0;
    mem_RE     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (req_bad)                        state_next = S_RESP;
          else if (req_op <= 3'(OP_LH))       state_next = S_LOAD;
          else if (op_e'(req_op) == OP_SW)    state_next = S_WRITE;
          else                                state_next = S_MERGE;
        end
      end
      S_LOAD: begin
        mem_RE     = 1'b1;
        state_next = S_RESP;
      end
      S_MERGE: begin
        mem_RE     = 1'b1;
        state_next = S_WRITE;
      end
      S_WRITE: begin
        mem_WE     = 1'b1;
        mem_WD     = wbuf;
        state_next = S_RESP;
      end
      S_RESP: begin
        resp_valid = 1'b1;
        resp_err   = err_q;
        resp_rdata = rdata_q;
        state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      op_q    <= OP_LW;
      addr_q  <= 32'h0;
      pc_q    <= 32'h0;
      wbuf    <= 32'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        op_q    <= op_e'(req_op);
        addr_q  <= req_addr;
        pc_q    <= req_pc;
        wbuf    <= req_wdata;
        rdata_q <= 32'h0;
        err_q   <= req_bad;
      end
      if (state == S_LOAD)  rdata_q <= ld_val;
      if (state == S_MERGE) wbuf    <= merge_val;
    end
  end

  assign mem_A  = {addr_q[31:2], 2'b00};
  assign mem_PC = pc_q;
  assign busy   = ~req_ready;

endmodule
